// File: rtl/riscv_fetch.sv
`timescale 1ns/1ps
// Instruction fetch unit: issues word-aligned reads to instruction memory,
// buffers in-order responses for decode, and handles redirects and faults.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fault
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << PTR_W;
  localparam int unsigned CNT_W = 3;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = DEPTH[CNT_W:0];

  typedef enum logic {RUN, FAULT} state_t;

  state_t             state_q, state_d;
  logic               fault_q, fault_d;
  logic               req_valid_q, req_valid_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [31:0]        buf_data_q [SLOTS];
  logic [31:0]        buf_data_d [SLOTS];
  logic [31:0]        buf_pc_q   [SLOTS];
  logic [31:0]        buf_pc_d   [SLOTS];

  logic               fire;
  logic               resp_eff;
  logic               in_run;
  logic               redir_ok;
  logic               redir_bad;
  logic               flush;
  logic               pop;
  logic               push;
  logic               can_issue;
  logic [CNT_W:0]     occ;
  logic [31:0]        base_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fire      = req_valid_q & imem_req_ready;
    // A response with nothing outstanding is stray and must not touch state.
    resp_eff  = imem_resp_valid & (inflight_q != '0);
    in_run    = (state_q == RUN);
    redir_ok  = in_run & redirect_valid & (redirect_pc[1:0] == 2'b00);
    redir_bad = in_run & redirect_valid & (redirect_pc[1:0] != 2'b00);
    flush     = redir_ok | redir_bad;
    pop       = (cnt_q != '0) & inst_ready;
    push      = resp_eff & in_run & ~flush & (drop_cnt_q == '0);

    state_d    = redir_bad ? FAULT : state_q;
    fault_d    = fault_q | redir_bad;
    inflight_d = inflight_q + CNT_W'(fire) - CNT_W'(resp_eff);

    // Everything still owed by memory, including a not-yet-fired request,
    // belongs to the old path once a redirect lands.
    drop_cnt_d = drop_cnt_q;
    if (redir_ok)
      drop_cnt_d = inflight_q + CNT_W'(req_valid_q) - CNT_W'(resp_eff);
    else if (resp_eff && (drop_cnt_q != '0))
      drop_cnt_d = drop_cnt_q - 1'b1;

    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        buf_data_d[tail_q] = imem_resp_data;
        buf_pc_d[tail_q]   = resp_pc_q;
        tail_d             = ptr_inc(tail_q);
      end
      if (pop)
        head_d = ptr_inc(head_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    resp_pc_d = resp_pc_q;
    if (redir_ok)
      resp_pc_d = redirect_pc;
    else if (push)
      resp_pc_d = resp_pc_q + 32'd4;

    // Issue decision uses post-edge occupancy; a pending request may only be
    // replaced once it fires, which keeps addr/valid stable until accepted.
    occ       = {1'b0, inflight_d} + {1'b0, cnt_d};
    can_issue = (state_d == RUN) & (~req_valid_q | fire) & (occ < DEPTH_C);
    base_pc   = redir_ok ? redirect_pc : fetch_pc_q;

    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    fetch_pc_d  = base_pc;
    if (can_issue) begin
      req_valid_d = 1'b1;
      req_addr_d  = base_pc;
      fetch_pc_d  = base_pc + 32'd4;
    end else if (fire) begin
      req_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fault_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      inflight_q  <= '0;
      drop_cnt_q  <= '0;
      cnt_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      inflight_q  <= inflight_d;
      drop_cnt_q  <= drop_cnt_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  // Buffer storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    buf_pc_q   <= buf_pc_d;
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign inst_valid     = (cnt_q != '0);
  assign inst           = inst_valid ? buf_data_q[head_q] : 32'h0;
  assign inst_pc        = inst_valid ? buf_pc_q[head_q]   : 32'h0;
  assign fault          = fault_q;

endmodule

// File: tb/tb_riscv_fetch.sv
`timescale 1ns/1ps
// Directed bench for riscv_fetch with a queue-based in-order memory model.
module tb_riscv_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        fault;

  int total = 0;
  int bad   = 0;

  logic        mem_en  = 1'b0;
  logic        mem_clr = 1'b1;
  logic        stray   = 1'b0;
  logic [31:0] mq [64];
  logic [5:0]  mh = 6'd0;
  logic [5:0]  mt = 6'd0;
  logic        mem_live;

  riscv_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  assign mem_live        = mem_en && (mh != mt);
  assign imem_resp_valid = mem_live || stray;
  assign imem_resp_data  = stray ? 32'hDEAD_BEEF : data_of(mq[mh]);

  always @(posedge clk) begin
    if (mem_clr) begin
      mh <= 6'd0;
      mt <= 6'd0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq[mt] <= imem_req_addr;
        mt     <= mt + 6'd1;
      end
      if (mem_live) mh <= mh + 6'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] pc);
    int n = 0;
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
    chk({tag, ".pc"}, inst_pc, pc);
    chk({tag, ".data"}, inst, data_of(pc));
    step();
  endtask

  // Hold reset for two edges with memory cleared; release mid-cycle.
  task automatic do_reset(input logic rdy, input logic irdy, input logic men);
    rst            = 1'b1;
    mem_clr        = 1'b1;
    mem_en         = 1'b0;
    redirect_valid = 1'b0;
    stray          = 1'b0;
    step();
    step();
    mem_clr        = 1'b0;
    imem_req_ready = rdy;
    inst_ready     = irdy;
    mem_en         = men;
    rst            = 1'b0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst.req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst.inst_valid", 32'(inst_valid), 32'd0);
    chk("rst.inst", inst, 32'd0);
    chk("rst.inst_pc", inst_pc, 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);

    // Streaming fetch from RESET_PC
    do_reset(1'b1, 1'b1, 1'b1);
    step();
    chk("a.req_valid", 32'(imem_req_valid), 32'd1);
    chk("a.req_addr", imem_req_addr, 32'h0);
    expect_inst("a0", 32'h0);
    expect_inst("a1", 32'h4);
    expect_inst("a2", 32'h8);

    // Decoder stalled: two requests fill the buffer, a pop frees one slot
    do_reset(1'b1, 1'b0, 1'b1);
    repeat (8) step();
    chk("b.fired", 32'(mt), 32'd2);
    chk("b.addr0", mq[0], 32'h0);
    chk("b.addr1", mq[1], 32'h4);
    chk("b.req_idle", 32'(imem_req_valid), 32'd0);
    chk("b.head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("b.req_again", 32'(imem_req_valid), 32'd1);
    chk("b.req_addr8", imem_req_addr, 32'h8);
    chk("b.head_pc4", inst_pc, 32'h4);

    // Redirect with two requests outstanding
    do_reset(1'b1, 1'b1, 1'b0);
    repeat (4) step();
    chk("c.req_idle", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("c.no_req_redirect", 32'(imem_req_valid), 32'd0);
    mem_en = 1'b1;
    step();
    chk("c.req_target", imem_req_addr, 32'h100);
    chk("c.req_valid", 32'(imem_req_valid), 32'd1);
    chk("c.no_stale", 32'(inst_valid), 32'd0);
    expect_inst("c0", 32'h100);
    expect_inst("c1", 32'h104);

    // Redirect coinciding with a response and a pop
    do_reset(1'b1, 1'b0, 1'b1);
    step();
    step();
    step();
    chk("d.head_pc", inst_pc, 32'h0);
    chk("d.resp_now", 32'(imem_resp_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    inst_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("d.flushed", 32'(inst_valid), 32'd0);
    chk("d.req_valid", 32'(imem_req_valid), 32'd1);
    chk("d.req_addr", imem_req_addr, 32'h200);
    expect_inst("d0", 32'h200);

    // Pending request held across redirect, then PC wrap
    do_reset(1'b0, 1'b1, 1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("e.hold_valid", 32'(imem_req_valid), 32'd1);
    chk("e.hold_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    step();
    chk("e.addr_top", imem_req_addr, 32'hFFFF_FFFC);
    step();
    chk("e.addr_wrap", imem_req_addr, 32'h0);
    expect_inst("e0", 32'hFFFF_FFFC);
    expect_inst("e1", 32'h0);

    // Misaligned redirect enters FAULT until reset
    do_reset(1'b1, 1'b0, 1'b1);
    step();
    step();
    step();
    chk("f.pre_valid", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
    chk("f.fault", 32'(fault), 32'd1);
    chk("f.inst_valid", 32'(inst_valid), 32'd0);
    chk("f.inst_zero", inst, 32'd0);
    chk("f.pc_zero", inst_pc, 32'd0);
    chk("f.req_off", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    repeat (4) step();
    chk("f.sticky", 32'(fault), 32'd1);
    chk("f.req_still_off", 32'(imem_req_valid), 32'd0);
    chk("f.inst_still_off", 32'(inst_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("f.async_fault", 32'(fault), 32'd0);
    chk("f.async_req", 32'(imem_req_valid), 32'd0);
    do_reset(1'b0, 1'b1, 1'b0);
    step();
    chk("f.restart_valid", 32'(imem_req_valid), 32'd1);
    chk("f.restart_addr", imem_req_addr, 32'h0);

    // Stray response with nothing outstanding is ignored
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    chk("g.stray_ignored", 32'(inst_valid), 32'd0);
    imem_req_ready = 1'b1;
    mem_en         = 1'b1;
    expect_inst("g0", 32'h0);
    expect_inst("g1", 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_fetch.md
RISCV_FETCH -- requirements
Module: riscv_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: DEPTH, default 2, instruction-buffer entries and max in-flight requests (range 1..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request present.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_resp_valid  input  1  fetch data returned, in request order.
REQ-009 imem_resp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  one-cycle pulse: change fetch PC (branch/jump from pc_sel).
REQ-011 redirect_pc  input  32  new fetch PC.
REQ-012 inst_valid  output  1  buffer head holds valid instruction for decoder.
REQ-013 inst  output  32  instruction word to decoder.
REQ-014 inst_pc  output  32  PC of inst.
REQ-015 inst_ready  input  1  decoder consumes head this cycle.
REQ-016 fault  output  1  sticky misaligned-redirect flag.

Function
REQ-017 States: RUN, FAULT; reset enters RUN.
REQ-018 Request handshake: fire = imem_req_valid & imem_req_ready; once asserted, imem_req_valid and imem_req_addr SHALL hold stable until fire, even across redirect.
REQ-019 Issue rule: new request raised only in RUN when (inflight + buf_cnt) < DEPTH, counting an un-fired pending request as in-flight.
REQ-020 fetch_pc increments by 4 per fire; 32-bit wrap (0xFFFF_FFFC -> 0x0000_0000), no flag.
REQ-021 inflight counter: +1 on fire, -1 on imem_resp_valid; simultaneous both -> unchanged.
REQ-022 Response with inflight==0 SHALL be ignored (no state change).
REQ-023 Accepted response written to buffer tail next edge with its PC; inst_valid rises the cycle after the response cycle (1-cycle latency).
REQ-024 Buffer is in-order FIFO; inst/inst_pc = head; inst_valid = (buf_cnt != 0); pop on inst_valid & inst_ready.
REQ-025 Push and pop in same cycle SHALL both occur; buf_cnt unchanged; full-buffer push cannot occur per REQ-019.
REQ-026 Redirect (RUN, redirect_pc[1:0]==0): buffer flushed, drop_cnt := inflight (incl. pending un-fired request and same-cycle response excluded), fetch_pc := redirect_pc.
REQ-027 While drop_cnt>0, responses SHALL be discarded and decrement drop_cnt; not written to buffer.
REQ-028 No new request raised in the redirect cycle; first request with addr = redirect_pc raised the next cycle, subject to REQ-019.
REQ-029 Redirect with same-cycle imem_resp_valid: response discarded. Same-cycle inst_ready: pop counted, flush dominates.
REQ-030 Redirect with redirect_pc[1:0]!=0: go to FAULT, fault=1, buffer flushed, no further requests raised (a pending un-fired request still completes), responses discarded.
REQ-031 FAULT exits only via rst.
REQ-032 When inst_valid=0, inst and inst_pc SHALL be 0.

Reset
REQ-033 rst asserted: immediately imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, fault=0, inflight=0, drop_cnt=0, buf_cnt=0, fetch_pc=RESET_PC, state RUN.
REQ-034 Reset mid-transaction: all in-flight responses forgotten; memory returning data after rst release with inflight==0 ignored per REQ-022.
REQ-035 First cycle after rst deasserted: imem_req_valid=1, imem_req_addr=RESET_PC.

Verification
REQ-036 Reset release, ready=1, 1-cycle memory returning 0x00000013 -> inst_valid=1 with inst_pc 0x0, 0x4, 0x8 on consecutive cycles while inst_ready=1.
REQ-037 inst_ready=0, DEPTH=2 -> exactly 2 requests fired (0x0, 0x4), imem_req_valid then 0 until a pop; pop frees one slot -> request 0x8.
REQ-038 Two requests in flight, redirect to 0x100 -> both late responses dropped, next inst_pc=0x100 with data from the 0x100 request.
REQ-039 Redirect coinciding with imem_resp_valid and inst_ready -> response discarded, buffer empty next cycle, imem_req_addr=target.
REQ-040 Redirect to 0x102 -> fault=1, imem_req_valid=0 thereafter, inst_valid=0; rst clears fault and restarts at RESET_PC.
REQ-041 fetch_pc 0xFFFF_FFFC fired -> next request address 0x0000_0000.
